// File: rtl/bus_sequencer.sv
// ---------------------------------------------------------------------------
// bus_sequencer
// Master timing controller for the shared system bus. Divides sys_clock into
// fixed CPU cycles, generates PHI2 and its edge strobes, holds CPU ready, and
// grants fixed bus slots to the video fetcher and the SPI/MCU bridge during
// PHI2 low. A registered owner code steers the RAM/IO address/data/WE muxes.
//
// Ports
//   sys_clock      in   system clock, rising-edge active
//   reset_n        in   asynchronous active-low reset
//   cpu_halt       in   CPU stall request, sampled once per CPU cycle
//   video_en       in   video fetch enable, sampled once per CPU cycle
//   spi_req        in   SPI bridge bus request (level)
//   cpu_clock      out  PHI2
//   cpu_clock_pe   out  1-cycle pulse coincident with PHI2 rising
//   cpu_clock_ne   out  1-cycle pulse coincident with PHI2 falling
//   cpu_ready      out  CPU RDY (0 stalls the CPU)
//   cpu_strobe     out  1-cycle RAM commit/latch pulse, last cycle before PHI2 falls
//   video_grant    out  high for the whole video slot
//   video_strobe   out  pulse on the last cycle of the video slot
//   spi_grant      out  high for the whole SPI slot
//   spi_strobe     out  pulse on the last cycle of the SPI slot
//   bus_owner      out  0 = CPU, 1 = VIDEO, 2 = SPI, 3 = IDLE
// ---------------------------------------------------------------------------
module bus_sequencer #(
    parameter int unsigned CYCLE_LEN        = 64,
    parameter int unsigned PHI2_RISE        = 32,
    parameter int unsigned VIDEO_SLOT_START = 4,
    parameter int unsigned VIDEO_SLOT_LEN   = 8,
    parameter int unsigned SPI_SLOT_START   = 16,
    parameter int unsigned SPI_SLOT_LEN     = 8
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic       cpu_halt,
    input  logic       video_en,
    input  logic       spi_req,
    output logic       cpu_clock,
    output logic       cpu_clock_pe,
    output logic       cpu_clock_ne,
    output logic       cpu_ready,
    output logic       cpu_strobe,
    output logic       video_grant,
    output logic       video_strobe,
    output logic       spi_grant,
    output logic       spi_strobe,
    output logic [1:0] bus_owner
);

    localparam int unsigned CW = $clog2(CYCLE_LEN);

    localparam logic [CW-1:0] CNT_LAST   = CW'(CYCLE_LEN - 1);
    localparam logic [CW-1:0] PHI2_AT    = CW'(PHI2_RISE);
    localparam logic [CW-1:0] VID_FIRST  = CW'(VIDEO_SLOT_START);
    localparam logic [CW-1:0] VID_LAST   = CW'(VIDEO_SLOT_START + VIDEO_SLOT_LEN - 1);
    localparam logic [CW-1:0] SPI_FIRST  = CW'(SPI_SLOT_START);
    localparam logic [CW-1:0] SPI_LAST   = CW'(SPI_SLOT_START + SPI_SLOT_LEN - 1);
    localparam logic [CW-1:0] SPI_SAMPLE = CW'(SPI_SLOT_START - 1);

    localparam logic [1:0] OWNER_CPU   = 2'd0;
    localparam logic [1:0] OWNER_VIDEO = 2'd1;
    localparam logic [1:0] OWNER_SPI   = 2'd2;
    localparam logic [1:0] OWNER_IDLE  = 2'd3;

    // Parameter sanity: both slots must sit inside PHI2 low and not overlap.
    if (CYCLE_LEN < 8 || PHI2_RISE == 0 || PHI2_RISE >= CYCLE_LEN) begin : g_bad_cycle
        $error("bus_sequencer: invalid CYCLE_LEN/PHI2_RISE");
    end
    if (VIDEO_SLOT_LEN == 0 || VIDEO_SLOT_START < 1 ||
        VIDEO_SLOT_START + VIDEO_SLOT_LEN > PHI2_RISE) begin : g_bad_video
        $error("bus_sequencer: video slot outside PHI2 low");
    end
    if (SPI_SLOT_LEN == 0 || SPI_SLOT_START < 1 ||
        SPI_SLOT_START + SPI_SLOT_LEN > PHI2_RISE) begin : g_bad_spi
        $error("bus_sequencer: SPI slot outside PHI2 low");
    end
    if (!(VIDEO_SLOT_START + VIDEO_SLOT_LEN <= SPI_SLOT_START ||
          SPI_SLOT_START + SPI_SLOT_LEN <= VIDEO_SLOT_START)) begin : g_bad_overlap
        $error("bus_sequencer: video and SPI slots overlap");
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          vid_en_q;
    logic          vid_en_nxt;
    logic          spi_go;
    logic          spi_go_nxt;
    logic          ready_nxt;
    logic          phi2_nxt;
    logic          pe_nxt;
    logic          ne_nxt;
    logic          cpu_strobe_nxt;
    logic          vgrant_nxt;
    logic          vstrobe_nxt;
    logic          sgrant_nxt;
    logic          sstrobe_nxt;
    logic [1:0]    owner_nxt;

    // Next-state decode: outputs are decoded from the count they will accompany,
    // so every registered output lines up with cnt in the same cycle.
    always_comb begin
        cnt_nxt        = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        ready_nxt      = cpu_ready;
        vid_en_nxt     = vid_en_q;
        spi_go_nxt     = spi_go;

        // CPU-cycle sample point: new halt/video state takes effect from cnt==0.
        if (cnt_nxt == '0) begin
            ready_nxt  = !cpu_halt;
            vid_en_nxt = video_en;
        end

        // SPI request is taken from the cycle just before the slot opens.
        if (cnt == SPI_SAMPLE) begin
            spi_go_nxt = spi_req;
        end

        phi2_nxt       = (cnt_nxt >= PHI2_AT);
        pe_nxt         = (cnt_nxt == PHI2_AT);
        ne_nxt         = (cnt_nxt == '0);
        cpu_strobe_nxt = (cnt_nxt == CNT_LAST);
        vgrant_nxt     = vid_en_nxt && (cnt_nxt >= VID_FIRST) && (cnt_nxt <= VID_LAST);
        vstrobe_nxt    = vid_en_nxt && (cnt_nxt == VID_LAST);
        sgrant_nxt     = spi_go_nxt && (cnt_nxt >= SPI_FIRST) && (cnt_nxt <= SPI_LAST);
        sstrobe_nxt    = spi_go_nxt && (cnt_nxt == SPI_LAST);

        owner_nxt = OWNER_IDLE;
        if (vgrant_nxt) begin
            owner_nxt = OWNER_VIDEO;
        end else if (sgrant_nxt) begin
            owner_nxt = OWNER_SPI;
        end else if (phi2_nxt) begin
            owner_nxt = OWNER_CPU;
        end
    end

    // State and output registers; reset aborts any slot without a strobe.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            vid_en_q     <= 1'b0;
            spi_go       <= 1'b0;
            cpu_clock    <= 1'b0;
            cpu_clock_pe <= 1'b0;
            cpu_clock_ne <= 1'b0;
            cpu_ready    <= 1'b0;
            cpu_strobe   <= 1'b0;
            video_grant  <= 1'b0;
            video_strobe <= 1'b0;
            spi_grant    <= 1'b0;
            spi_strobe   <= 1'b0;
            bus_owner    <= OWNER_IDLE;
        end else begin
            cnt          <= cnt_nxt;
            vid_en_q     <= vid_en_nxt;
            spi_go       <= spi_go_nxt;
            cpu_clock    <= phi2_nxt;
            cpu_clock_pe <= pe_nxt;
            cpu_clock_ne <= ne_nxt;
            cpu_ready    <= ready_nxt;
            cpu_strobe   <= cpu_strobe_nxt;
            video_grant  <= vgrant_nxt;
            video_strobe <= vstrobe_nxt;
            spi_grant    <= sgrant_nxt;
            spi_strobe   <= sstrobe_nxt;
            bus_owner    <= owner_nxt;
        end
    end

endmodule
